// File: rtl/dwt_band_feature_pkg.sv
// Shared types and constants for the DWT band feature extractor.
package dwt_band_feature_pkg;

  // Coefficient format: signed Q2.29 on the input, magnitudes share the width.
  localparam int COEFF_W = 32;
  localparam int FRAC_W  = 29;
  localparam int ZC_W    = 16;

  // Windowing control states; the output stage is a register bank, not a state.
  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  // One completed window's features.
  typedef struct packed {
    logic [COEFF_W-1:0] mav;
    logic [COEFF_W-1:0] energy;
    logic [ZC_W-1:0]    zero_cross;
  } feat_t;

endpackage

// File: rtl/dwt_band_feature_abs_sq_unit.sv
// Combinational magnitude and square of one coefficient.
// The magnitude saturates the most negative code to the largest positive one;
// the square uses only the upper 16 bits (signed), so it always fits in 32 bits.
module abs_sq_unit
  import dwt_band_feature_pkg::*;
(
  input  logic [COEFF_W-1:0] coeff,
  output logic [COEFF_W-1:0] abs_val,
  output logic [COEFF_W-1:0] sq_val
);

  logic signed [15:0] hi;
  logic signed [31:0] prod;

  // Saturating absolute value.
  always_comb begin
    abs_val = coeff;
    if (coeff == 32'h8000_0000) begin
      abs_val = 32'h7FFF_FFFF;
    end else if (coeff[COEFF_W-1]) begin
      abs_val = ~coeff + 32'd1;
    end else begin
      abs_val = coeff;
    end
  end

  // Signed 16x16 square of the upper half; largest result is 2^30.
  assign hi     = signed'(coeff[31:16]);
  assign prod   = 32'(hi) * 32'(hi);
  assign sq_val = unsigned'(prod);

endmodule

// File: rtl/dwt_band_feature.sv
// Windowed feature extractor for one DWT band: decimates the incoming filter
// stream, accumulates |x|, x_hi^2 and sign changes over WIN_LEN kept samples,
// and publishes mean abs value, mean energy and zero-crossing count per window.
module dwt_band_feature
  import dwt_band_feature_pkg::*;
#(
  parameter int WIN_LEN = 64,
  parameter int DECIM   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               start,
  input  logic               in_valid,
  input  logic [COEFF_W-1:0] in_coeff,
  output logic [COEFF_W-1:0] mav,
  output logic [COEFF_W-1:0] energy,
  output logic [ZC_W-1:0]    zero_cross,
  output logic               feat_valid,
  output logic               busy
);

  localparam int LOG2_WIN = $clog2(WIN_LEN);
  localparam int ACC_W    = COEFF_W + LOG2_WIN;
  localparam int PH_W     = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [PH_W-1:0]     PH_LAST  = PH_W'(DECIM - 1);
  localparam logic [LOG2_WIN-1:0] CNT_LAST = LOG2_WIN'(WIN_LEN - 1);

  state_t              state;
  logic [PH_W-1:0]     phase;
  logic [LOG2_WIN-1:0] cnt;
  logic [ACC_W-1:0]    sum_abs;
  logic [ACC_W-1:0]    sum_sq;
  logic [ZC_W-1:0]     zc;
  logic                have_prev;
  logic                prev_sign;
  feat_t               feat;
  logic                feat_valid_r;

  logic [COEFF_W-1:0]  abs_val;
  logic [COEFF_W-1:0]  sq_val;
  logic [ACC_W-1:0]    sum_abs_nxt;
  logic [ACC_W-1:0]    sum_sq_nxt;
  logic [ZC_W-1:0]     zc_nxt;
  logic                zc_inc;

  abs_sq_unit u_abs_sq (
    .coeff   (in_coeff),
    .abs_val (abs_val),
    .sq_val  (sq_val)
  );

  // Running totals including the sample currently on the input.
  always_comb begin
    zc_inc      = have_prev && (in_coeff[COEFF_W-1] != prev_sign);
    sum_abs_nxt = sum_abs + ACC_W'(abs_val);
    sum_sq_nxt  = sum_sq + ACC_W'(sq_val);
    zc_nxt      = zc + ZC_W'(zc_inc);
  end

  // Window control, decimation, accumulation and the feature output bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      phase        <= '0;
      cnt          <= '0;
      sum_abs      <= '0;
      sum_sq       <= '0;
      zc           <= '0;
      have_prev    <= 1'b0;
      prev_sign    <= 1'b0;
      feat         <= '0;
      feat_valid_r <= 1'b0;
    end else begin
      feat_valid_r <= 1'b0;
      case (state)
        IDLE: begin
          // Samples arriving with the start pulse are not part of the window.
          if (en && start) begin
            state     <= ACCUM;
            phase     <= '0;
            cnt       <= '0;
            sum_abs   <= '0;
            sum_sq    <= '0;
            zc        <= '0;
            have_prev <= 1'b0;
            prev_sign <= 1'b0;
          end
        end
        ACCUM: begin
          if (!en) begin
            // Partial window is dropped; published features stay as they were.
            state <= IDLE;
          end else if (in_valid) begin
            phase <= (phase == PH_LAST) ? '0 : phase + PH_W'(1);
            if (phase == '0) begin
              if (cnt == CNT_LAST) begin
                feat.mav        <= sum_abs_nxt[ACC_W-1:LOG2_WIN];
                feat.energy     <= sum_sq_nxt[ACC_W-1:LOG2_WIN];
                feat.zero_cross <= zc_nxt;
                feat_valid_r    <= 1'b1;
                // Next window begins immediately; its first sample must not
                // count as a crossing against this window's last one.
                cnt       <= '0;
                sum_abs   <= '0;
                sum_sq    <= '0;
                zc        <= '0;
                have_prev <= 1'b0;
                prev_sign <= 1'b0;
              end else begin
                cnt       <= cnt + LOG2_WIN'(1);
                sum_abs   <= sum_abs_nxt;
                sum_sq    <= sum_sq_nxt;
                zc        <= zc_nxt;
                have_prev <= 1'b1;
                prev_sign <= in_coeff[COEFF_W-1];
              end
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign mav        = feat.mav;
  assign energy     = feat.energy;
  assign zero_cross = feat.zero_cross;
  assign feat_valid = feat_valid_r;
  assign busy       = (state == ACCUM);

endmodule

// File: tb/tb_dwt_band_feature.sv
// Self-checking bench for dwt_band_feature with WIN_LEN=4: directed window
// table, multi-cycle corner sequences and randomized traffic against a
// queue-based reference model.
module tb_dwt_band_feature;

  localparam int WL = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        start;
  logic        in_valid;
  logic [31:0] in_coeff;
  logic [31:0] mav;
  logic [31:0] energy;
  logic [15:0] zero_cross;
  logic        feat_valid;
  logic        busy;

  always #5 clk = ~clk;

  dwt_band_feature #(.WIN_LEN(WL), .DECIM(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .start      (start),
    .in_valid   (in_valid),
    .in_coeff   (in_coeff),
    .mav        (mav),
    .energy     (energy),
    .zero_cross (zero_cross),
    .feat_valid (feat_valid),
    .busy       (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int pulse_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  bit          m_active;
  int          m_nvalid;
  logic [31:0] kept[$];
  logic [31:0] m_mav, m_energy;
  logic [15:0] m_zc;
  bit          m_fv;

  function automatic longint abs_of(input logic [31:0] c);
    int x;
    x = signed'(c);
    if (c == 32'h8000_0000) return 64'h7FFF_FFFF;
    if (x < 0) return -longint'(x);
    return longint'(x);
  endfunction

  function automatic longint sq_of(input logic [31:0] c);
    shortint h;
    h = signed'(c[31:16]);
    return longint'(h) * longint'(h);
  endfunction

  task automatic model_reset();
    m_active = 0; m_nvalid = 0; kept.delete();
    m_mav = '0; m_energy = '0; m_zc = '0; m_fv = 0;
  endtask

  task automatic model_step(input bit e, input bit s, input bit v, input logic [31:0] c);
    longint sa, ss;
    int     z;
    m_fv = 0;
    if (!m_active) begin
      if (e && s) begin
        m_active = 1; m_nvalid = 0; kept.delete();
      end
    end else if (!e) begin
      m_active = 0;
    end else if (v) begin
      if (m_nvalid % 2 == 0) kept.push_back(c);
      m_nvalid++;
      if (kept.size() == WL) begin
        sa = 0; ss = 0; z = 0;
        foreach (kept[i]) begin
          sa += abs_of(kept[i]);
          ss += sq_of(kept[i]);
          if (i > 0 && kept[i][31] != kept[i-1][31]) z++;
        end
        m_mav    = 32'(sa / WL);
        m_energy = 32'(ss / WL);
        m_zc     = 16'(z);
        m_fv     = 1;
        kept.delete();
      end
    end
  endtask

  // One clock: drive inputs, step the model at the edge, compare just after.
  task automatic cycle(input bit e, input bit s, input bit v, input logic [31:0] c);
    en = e; start = s; in_valid = v; in_coeff = c;
    @(posedge clk);
    model_step(e, s, v, c);
    #1;
    check("feat_valid", 64'(feat_valid), 64'(m_fv));
    check("busy", 64'(busy), 64'(m_active));
    check("mav", 64'(mav), 64'(m_mav));
    check("energy", 64'(energy), 64'(m_energy));
    check("zero_cross", 64'(zero_cross), 64'(m_zc));
    if (feat_valid) pulse_cnt++;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_mav"}, 64'(mav), 64'd0);
    check({tag, "_energy"}, 64'(energy), 64'd0);
    check({tag, "_zc"}, 64'(zero_cross), 64'd0);
    check({tag, "_fv"}, 64'(feat_valid), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  // ---------------- directed window table ----------------
  typedef struct {
    logic [3:0][31:0] pat;
    logic [31:0]      exp_mav;
    logic [31:0]      exp_energy;
    logic [15:0]      exp_zc;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int p0, idx[$];
    logic [31:0] c;

    vecs[0].pat = {32'h2000_0000, 32'h2000_0000, 32'h2000_0000, 32'h2000_0000};
    vecs[0].exp_mav = 32'h2000_0000; vecs[0].exp_energy = 32'h0400_0000; vecs[0].exp_zc = 16'd0;
    // pat[0] is the first sample: +,+,-,-
    vecs[1].pat = {32'hF000_0000, 32'hF000_0000, 32'h1000_0000, 32'h1000_0000};
    vecs[1].exp_mav = 32'h1000_0000; vecs[1].exp_energy = 32'h0100_0000; vecs[1].exp_zc = 16'd3;
    vecs[2].pat = {32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    vecs[2].exp_mav = 32'h7FFF_FFFF; vecs[2].exp_energy = 32'h4000_0000; vecs[2].exp_zc = 16'd0;
    // kept: 7FFFFFFF, -1, 7FFFFFFF, -1 (odd positions are skipped)
    vecs[3].pat = {32'h1234_5678, 32'hFFFF_FFFF, 32'h0BAD_F00D, 32'h7FFF_FFFF};
    vecs[3].exp_mav = 32'h4000_0000; vecs[3].exp_energy = 32'h1FFF_8001; vecs[3].exp_zc = 16'd3;

    rst = 1'b1; en = 1'b0; start = 1'b0; in_valid = 1'b0; in_coeff = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst = 1'b0;

    // Table: start (with a sample that must be ignored), 8 valids, idle.
    foreach (vecs[t]) begin
      p0 = pulse_cnt;
      cycle(1, 1, 1, 32'h7777_7777);
      for (int k = 0; k < 8; k++) cycle(1, 0, 1, vecs[t].pat[k % 4]);
      check("tbl_pulses", 64'(pulse_cnt - p0), 64'd1);
      check("tbl_mav", 64'(mav), 64'(vecs[t].exp_mav));
      check("tbl_energy", 64'(energy), 64'(vecs[t].exp_energy));
      check("tbl_zc", 64'(zero_cross), 64'(vecs[t].exp_zc));
      cycle(0, 0, 0, 32'h0);
    end

    // Continuous windows: 16 back-to-back valids give pulses after valid 6 and 14.
    cycle(1, 1, 0, 32'h0);
    for (int k = 0; k < 16; k++) begin
      p0 = pulse_cnt;
      cycle(1, 0, 1, $urandom);
      if (pulse_cnt != p0) idx.push_back(k);
    end
    check("b2b_count", 64'(idx.size()), 64'd2);
    if (idx.size() == 2) begin
      check("b2b_first", 64'(idx[0]), 64'd6);
      check("b2b_gap", 64'(idx[1] - idx[0]), 64'd8);
    end
    cycle(0, 0, 0, 32'h0);

    // Abort: re-run the last table window, then 5 valids and en low.
    cycle(1, 1, 0, 32'h0);
    for (int k = 0; k < 8; k++) cycle(1, 0, 1, vecs[3].pat[k % 4]);
    cycle(1, 1, 0, 32'h0);  // start while busy is ignored
    p0 = pulse_cnt;
    for (int k = 0; k < 5; k++) cycle(1, 0, 1, 32'h5555_0000);
    cycle(0, 0, 1, 32'h5555_0000);
    cycle(1, 0, 1, 32'h5555_0000);
    cycle(1, 0, 1, 32'h5555_0000);
    check("abort_pulses", 64'(pulse_cnt - p0), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_mav_hold", 64'(mav), 64'(vecs[3].exp_mav));
    check("abort_energy_hold", 64'(energy), 64'(vecs[3].exp_energy));

    // Asynchronous reset in the middle of a window.
    cycle(1, 1, 0, 32'h0);
    for (int k = 0; k < 8; k++) cycle(1, 0, 1, 32'h2000_0000);
    for (int k = 0; k < 3; k++) cycle(1, 0, 1, 32'hE000_0000);
    #2 rst = 1'b1;
    #1;
    check_zero_outputs("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    check_zero_outputs("rst_held");
    rst = 1'b0;
    p0 = pulse_cnt;
    for (int k = 0; k < 12; k++) cycle(1, 0, 1, 32'h3000_0000);
    check("post_rst_pulses", 64'(pulse_cnt - p0), 64'd0);

    // Randomized traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      c = $urandom;
      case ($urandom_range(0, 15))
        0: c = 32'h8000_0000;
        1: c = 32'h7FFF_FFFF;
        2: c = 32'h0000_0000;
        3: c = 32'hFFFF_FFFF;
        default: ;
      endcase
      cycle(($urandom % 50) != 0, ($urandom % 16) == 0, ($urandom % 4) != 0, c);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dwt_band_feature.md
DWT_BAND_FEATURE -- requirements
Module: dwt_band_feature

Interface
REQ-001 The module SHALL have parameter WIN_LEN, default 64, meaning the number of decimated coefficients per feature window (power of two, 4..4096).
REQ-002 The module SHALL have parameter DECIM, default 2, meaning the decimation factor applied to the incoming filter stream (fixed at 2 for the DWT).
REQ-003 Port clk  input  1  system clock; all logic is on the rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port en  input  1  block enable; low aborts any window and holds the block idle.
REQ-006 Port start  input  1  single-cycle pulse that arms windowing.
REQ-007 Port in_valid  input  1  qualifies in_coeff for one cycle.
REQ-008 Port in_coeff  input  32  signed Q2.29 coefficient from the highpass/lowpass decomposition filter.
REQ-009 Port mav  output  32  unsigned mean absolute value of the window, Q2.29 magnitude.
REQ-010 Port energy  output  32  unsigned mean of squared coefficients: in_coeff[31:16] squared, Q4.26.
REQ-011 Port zero_cross  output  16  count of sign changes between consecutive kept coefficients in the window.
REQ-012 Port feat_valid  output  1  one-cycle pulse qualifying mav/energy/zero_cross.
REQ-013 Port busy  output  1  high while in state ACCUM.

Function
REQ-014 FSM states SHALL be IDLE and ACCUM only; the output stage is a register bank, not a state.
REQ-015 IDLE->ACCUM SHALL occur on start=1 with en=1; ACCUM->IDLE SHALL occur on en=0; start in ACCUM SHALL be ignored.
REQ-016 On entering ACCUM, phase, sample counter, sum_abs, sum_sq, zc counter and prev-sign flag SHALL be cleared.
REQ-017 In ACCUM, each in_valid=1 cycle SHALL toggle phase; only samples with phase=0 (1st, 3rd, 5th, ...) SHALL be kept.
REQ-018 Kept sample abs SHALL be |in_coeff|, with -2^31 saturating to 0x7FFF_FFFF; sum_abs SHALL be 32+log2(WIN_LEN) bits unsigned.
REQ-019 Kept sample square SHALL be in_coeff[31:16]*in_coeff[31:16] (32-bit unsigned); sum_sq SHALL be 32+log2(WIN_LEN) bits.
REQ-020 zc SHALL increment when a kept sample's sign bit differs from the previous kept sample's in the same window; the first kept sample of a window SHALL NOT count.
REQ-021 When the WIN_LEN-th kept sample is accepted, mav=(sum_abs+abs)>>log2(WIN_LEN), energy=(sum_sq+sq)>>log2(WIN_LEN), zero_cross=final zc SHALL be registered, and feat_valid SHALL pulse on the next cycle (latency 1 cycle from the last kept sample).
REQ-022 In that same cycle the accumulators SHALL clear and the next window SHALL start with no sample lost (continuous windows); phase continues uninterrupted.
REQ-023 mav/energy/zero_cross SHALL hold their value between feat_valid pulses.
REQ-024 in_valid outside ACCUM SHALL be ignored.
REQ-025 en=0 mid-window SHALL discard the partial window without asserting feat_valid; outputs SHALL retain last completed window values.
REQ-026 in_valid on the same cycle as the start pulse SHALL be ignored; the first sample counted is the first valid after ACCUM is entered.

Reset
REQ-027 rst=1 SHALL asynchronously force IDLE, clear all counters/accumulators/phase, and drive mav=0, energy=0, zero_cross=0, feat_valid=0, busy=0.
REQ-028 rst mid-window SHALL drop the window; after release the block SHALL require a new start.

Structure
REQ-029 A shared package SHALL hold the state enum (IDLE, ACCUM), the Q-format width constants (COEFF_W=32, FRAC_W=29) and the feature output struct type.
REQ-030 One sub-module abs_sq_unit SHALL compute saturated abs and the 16x16 square combinationally; all else is in this module.

Verification (WIN_LEN=4 override)
REQ-031 start, then 8 valids of 0x2000_0000 -> one feat_valid; mav=0x2000_0000, energy=0x0400_0000, zero_cross=0.
REQ-032 start, then repeating +0x1000_0000,+0x1000_0000,-0x1000_0000,-0x1000_0000 (8 valids) -> mav=0x1000_0000, energy=0x0100_0000, zero_cross=3.
REQ-033 start, then 8 valids of 0x8000_0000 -> mav=0x7FFF_FFFF, energy=0x4000_0000.
REQ-034 start, 16 back-to-back valids -> exactly 2 feat_valid pulses, 8 cycles apart, each 1 cycle after the 4th kept sample.
REQ-035 start, 5 valids, en=0 for 1 cycle -> no feat_valid, busy=0; outputs unchanged.
REQ-036 rst pulse asserted mid-window, asynchronous to clk -> outputs 0 immediately; later valids without start produce no feat_valid.
